// File: rtl/lt24_pixel_arbiter_if.sv
// Pixel-write bus between two requesters, the arbiter and the LT24 driver.
// slave  : arbiter view (takes requests, drives the driver side)
// master : environment view (requesters + driver model)
interface lt24_pixel_arbiter_if #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 9,
    parameter int DATA_WIDTH = 16
);
    logic                  req0Write;
    logic [X_WIDTH-1:0]    req0X;
    logic [Y_WIDTH-1:0]    req0Y;
    logic [DATA_WIDTH-1:0] req0Data;
    logic                  req0Ack;
    logic                  req1Write;
    logic [X_WIDTH-1:0]    req1X;
    logic [Y_WIDTH-1:0]    req1Y;
    logic [DATA_WIDTH-1:0] req1Data;
    logic                  req1Ack;
    logic [1:0]            grant;
    logic                  pixelWrite;
    logic [X_WIDTH-1:0]    xAddr;
    logic [Y_WIDTH-1:0]    yAddr;
    logic [DATA_WIDTH-1:0] pixelData;
    logic                  pixelReady;

    modport slave (
        input  req0Write, req0X, req0Y, req0Data,
        input  req1Write, req1X, req1Y, req1Data,
        input  pixelReady,
        output req0Ack, req1Ack, grant, pixelWrite, xAddr, yAddr, pixelData
    );

    modport master (
        output req0Write, req0X, req0Y, req0Data,
        output req1Write, req1X, req1Y, req1Data,
        output pixelReady,
        input  req0Ack, req1Ack, grant, pixelWrite, xAddr, yAddr, pixelData
    );
endinterface

// File: rtl/lt24_pixel_arbiter.sv
// Two-requester arbiter in front of the LT24 pixel-write port.
// Round-robin with bounded burst ownership; payload registered toward the driver.
// Build option: ARB_FIXED_PRIORITY_EN -- requester 0 always wins in IDLE
// (no burst limit, requester 1 may starve).
//
// state | meaning
// IDLE  | no pixel outstanding; pick an owner and capture its payload
// XFER  | pixelWrite held with stable payload until the driver takes it
module lt24_pixel_arbiter #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 9,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    lt24_pixel_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  capture;
    logic                  accept;
    logic                  owner_nxt;
    logic                  pixel_write_q;
    logic [1:0]            grant_q;
    logic [X_WIDTH-1:0]    x_q;
    logic [Y_WIDTH-1:0]    y_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            req;

    assign req = {bus.req1Write, bus.req0Write};

`ifdef ARB_FIXED_PRIORITY_EN
    // Requester 0 wins whenever it asks.
    always_comb owner_nxt = ~req[0];
`else
    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

    logic          last_owner;
    logic [BW-1:0] burst_count;
    logic          burst_open;

    // A burst is only "open" once the last owner has actually written a pixel,
    // so the reset value lastOwner=1 with an empty count hands the first tie to 0.
    assign burst_open = (burst_count != '0) && (burst_count < BURST_MAX);

    // Owner choice: lone requester wins; on contention keep an open burst, else rotate.
    always_comb begin
        owner_nxt = ~last_owner;
        if (req[0] ^ req[1])
            owner_nxt = req[1];
        else if (burst_open)
            owner_nxt = last_owner;
    end

    // Burst length and last owner tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            burst_count <= '0;
            last_owner  <= 1'b1;
        end else if (accept) begin
            last_owner <= grant_q[1];
            if (burst_count != BURST_MAX)
                burst_count <= burst_count + 1'b1;
        end else if (state == IDLE &&
                     (!req[last_owner] || (capture && owner_nxt != last_owner))) begin
            burst_count <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and capture/accept strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    capture   = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (bus.pixelReady) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered strobe, grant and payload toward the driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_write_q <= 1'b0;
            grant_q       <= 2'b00;
            x_q           <= '0;
            y_q           <= '0;
            data_q        <= '0;
        end else if (capture) begin
            pixel_write_q <= 1'b1;
            grant_q       <= owner_nxt ? 2'b10 : 2'b01;
            x_q           <= owner_nxt ? bus.req1X    : bus.req0X;
            y_q           <= owner_nxt ? bus.req1Y    : bus.req0Y;
            data_q        <= owner_nxt ? bus.req1Data : bus.req0Data;
        end else if (accept) begin
            pixel_write_q <= 1'b0;
            grant_q       <= 2'b00;
        end
    end

    assign bus.pixelWrite = pixel_write_q;
    assign bus.grant      = grant_q;
    assign bus.xAddr      = x_q;
    assign bus.yAddr      = y_q;
    assign bus.pixelData  = data_q;

    // Acks are masked during reset so an abandoned transfer never reports completion.
    assign bus.req0Ack = pixel_write_q & bus.pixelReady & grant_q[0] & ~reset;
    assign bus.req1Ack = pixel_write_q & bus.pixelReady & grant_q[1] & ~reset;
endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Self-checking bench for lt24_pixel_arbiter: directed scenarios plus
// randomized traffic scored against a behavioural arbitration model.
module tb_lt24_pixel_arbiter;
    localparam int MAXB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    lt24_pixel_arbiter_if #(.X_WIDTH(8), .Y_WIDTH(9), .DATA_WIDTH(16)) bus ();

    lt24_pixel_arbiter #(
        .X_WIDTH(8), .Y_WIDTH(9), .DATA_WIDTH(16), .MAX_BURST(MAXB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Requester state and model state
    bit          rq[2];
    logic [7:0]  px[2];
    logic [8:0]  py[2];
    logic [15:0] pd[2];
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_streak;
    logic [7:0]  ex;
    logic [8:0]  ey;
    logic [15:0] ed;
    int          cyc;
    int          grant_log[$];
    int          ack_times[$];

    task automatic drive_bus(input bit ready);
        bus.req0Write  = rq[0];
        bus.req0X      = px[0];
        bus.req0Y      = py[0];
        bus.req0Data   = pd[0];
        bus.req1Write  = rq[1];
        bus.req1X      = px[1];
        bus.req1Y      = py[1];
        bus.req1Data   = pd[1];
        bus.pixelReady = ready;
    endtask

    task automatic do_reset();
        rq[0] = 0;
        rq[1] = 0;
        drive_bus(1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        m_busy   = 0;
        m_owner  = 0;
        m_last   = 1;
        m_streak = 0;
        cyc      = 0;
        grant_log.delete();
        ack_times.delete();
    endtask

    // Starts and ends at 1 time unit after a rising edge.
    task automatic run_traffic(input int cycles, input int p_req, input int p_ready);
        bit       ready;
        bit [1:0] exp_g;
        bit       ea0, ea1;
        int       o;
        for (int c = 0; c < cycles; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rq[r] && ($urandom_range(99) < p_req)) begin
                    rq[r] = 1;
                    px[r] = 8'($urandom_range(239));
                    py[r] = 9'($urandom_range(319));
                    pd[r] = 16'($urandom);
                end
            end
            ready = ($urandom_range(99) < p_ready);
            drive_bus(ready);
            @(negedge clock);
            cyc++;
            exp_g = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            ea0   = m_busy && (m_owner == 0) && ready;
            ea1   = m_busy && (m_owner == 1) && ready;
            checks++;
            if (bus.pixelWrite !== m_busy) begin
                errors++;
                $display("FAIL traffic_pixelWrite cyc=%0d got %b want %b", cyc, bus.pixelWrite, m_busy);
            end
            checks++;
            if (bus.grant !== exp_g) begin
                errors++;
                $display("FAIL traffic_grant cyc=%0d got %b want %b", cyc, bus.grant, exp_g);
            end
            checks++;
            if (bus.req0Ack !== ea0 || bus.req1Ack !== ea1) begin
                errors++;
                $display("FAIL traffic_ack cyc=%0d got %b%b want %b%b", cyc,
                         bus.req1Ack, bus.req0Ack, ea1, ea0);
            end
            if (m_busy) begin
                checks++;
                if (bus.xAddr !== ex || bus.yAddr !== ey || bus.pixelData !== ed) begin
                    errors++;
                    $display("FAIL traffic_payload cyc=%0d got %h/%h/%h want %h/%h/%h", cyc,
                             bus.xAddr, bus.yAddr, bus.pixelData, ex, ey, ed);
                end
            end
            // Model: one decision per idle cycle, one completion per accepted cycle.
            if (m_busy) begin
                if (ready) begin
                    if (m_owner == m_last)
                        m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
                    else
                        m_streak = 1;
                    m_last      = m_owner;
                    m_busy      = 0;
                    rq[m_owner] = 0;
                    ack_times.push_back(cyc);
                end
            end else begin
                if (!rq[m_last])
                    m_streak = 0;
                if (rq[0] || rq[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    o = rq[0] ? 0 : 1;
`else
                    if (rq[0] && rq[1])
                        o = (m_streak > 0 && m_streak < MAXB) ? m_last : 1 - m_last;
                    else
                        o = rq[0] ? 0 : 1;
`endif
                    m_busy  = 1;
                    m_owner = o;
                    ex      = px[o];
                    ey      = py[o];
                    ed      = pd[o];
                    grant_log.push_back(o);
                end
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        rq[0] = 1;
        rq[1] = 0;
        px[0] = 8'd7;
        py[0] = 9'd9;
        pd[0] = 16'h1234;
        drive_bus(1'b0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if (bus.pixelWrite !== 1'b0 || bus.grant !== 2'b00 || bus.req0Ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got pw=%b grant=%b want pw=0 grant=00", bus.pixelWrite, bus.grant);
            end
            checks++;
            if (bus.xAddr !== 8'd0 || bus.yAddr !== 9'd0 || bus.pixelData !== 16'd0) begin
                errors++;
                $display("FAIL reset_payload got %h/%h/%h want 0/0/0", bus.xAddr, bus.yAddr, bus.pixelData);
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (bus.pixelWrite !== 1'b1 || bus.grant !== 2'b01 || bus.pixelData !== 16'h1234) begin
            errors++;
            $display("FAIL reset_release got pw=%b grant=%b data=%h want pw=1 grant=01 data=1234",
                     bus.pixelWrite, bus.grant, bus.pixelData);
        end
        do_reset();
    endtask

    task automatic test_stall_payload();
        int acks = 0;
        rq[0] = 1;
        px[0] = 8'd10;
        py[0] = 9'd20;
        pd[0] = 16'hF800;
        drive_bus(1'b0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 6; i++) begin
            drive_bus(i == 5);
            @(negedge clock);
            checks++;
            if (bus.pixelWrite !== 1'b1 || bus.xAddr !== 8'd10 || bus.yAddr !== 9'd20 ||
                bus.pixelData !== 16'hF800 || bus.grant !== 2'b01) begin
                errors++;
                $display("FAIL stall_payload i=%0d got pw=%b %0d/%0d/%h want pw=1 10/20/f800",
                         i, bus.pixelWrite, bus.xAddr, bus.yAddr, bus.pixelData);
            end
            checks++;
            if (bus.req0Ack !== (i == 5) || bus.req1Ack !== 1'b0) begin
                errors++;
                $display("FAIL stall_ack i=%0d got %b want %b", i, bus.req0Ack, (i == 5));
            end
            if (bus.req0Ack === 1'b1) acks++;
            @(posedge clock);
            #1;
        end
        rq[0] = 0;
        drive_bus(1'b1);
        @(negedge clock);
        checks++;
        if (bus.pixelWrite !== 1'b0 || bus.grant !== 2'b00 || bus.req0Ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_after got pw=%b grant=%b ack=%b want 0/00/0", bus.pixelWrite, bus.grant, bus.req0Ack);
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL stall_ack_count got %0d want 1", acks);
        end
        @(posedge clock);
        #1;
        do_reset();
    endtask

    task automatic test_round_robin();
        int e;
        run_traffic(80, 100, 100);
        checks++;
        if (grant_log.size() < 40) begin
            errors++;
            $display("FAIL rr_count got %0d want >=40", grant_log.size());
        end
        for (int k = 0; k < grant_log.size(); k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            e = 0;
`else
            e = (k / MAXB) % 2;
`endif
            checks++;
            if (grant_log[k] != e) begin
                errors++;
                $display("FAIL rr_sequence k=%0d got %0d want %0d", k, grant_log[k], e);
            end
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        run_traffic(40, 100, 100);
        checks++;
        if (ack_times.size() < 19) begin
            errors++;
            $display("FAIL b2b_count got %0d want >=19", ack_times.size());
        end
        for (int i = 1; i < ack_times.size(); i++) begin
            checks++;
            if (ack_times[i] - ack_times[i-1] != 2) begin
                errors++;
                $display("FAIL b2b_spacing i=%0d got %0d want 2", i, ack_times[i] - ack_times[i-1]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_xfer();
        logic [1:0] exp_g;
        rq[1] = 1;
        pd[1] = 16'h07E0;
        drive_bus(1'b1);
        @(posedge clock);
        #1;
        checks++;
        if (bus.req1Ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_first_ack got %b want 1", bus.req1Ack);
        end
        @(posedge clock);
        #1;
        rq[0] = 1;
        rq[1] = 1;
        drive_bus(1'b0);
        @(posedge clock);
        #1;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        checks++;
        if (bus.grant !== exp_g || bus.pixelWrite !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_grant got %b want %b", bus.grant, exp_g);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.req0Ack !== 1'b0 || bus.req1Ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ack got %b%b want 00", bus.req1Ack, bus.req0Ack);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.pixelWrite !== 1'b0 || bus.grant !== 2'b00 || bus.req1Ack !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got pw=%b grant=%b want pw=0 grant=00", bus.pixelWrite, bus.grant);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (bus.grant !== 2'b01 || bus.pixelWrite !== 1'b1) begin
            errors++;
            $display("FAIL midrst_tie got grant=%b want 01", bus.grant);
        end
        do_reset();
    endtask

    task automatic test_random();
        run_traffic(1500, 60, 50);
        do_reset();
        run_traffic(1500, 30, 80);
        do_reset();
    endtask

    initial begin
        rq[0] = 0;
        rq[1] = 0;
        px[0] = '0; px[1] = '0;
        py[0] = '0; py[1] = '0;
        pd[0] = '0; pd[1] = '0;
        drive_bus(1'b0);
        test_reset();
        test_stall_payload();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_xfer();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
